// File: rtl/priority_cd_if.sv
// Bus bundle for the registered priority encoder: input vector, index and valid flag.
// The TB drives through the master side; the encoder sits on the slave side.
interface priority_cd_if #(
    parameter int IN_WIDTH = 8
);
    localparam int OUT_WIDTH = $clog2(IN_WIDTH);

    logic [IN_WIDTH-1:0]  in;
    logic [OUT_WIDTH-1:0] out;
    logic                 valid;

    modport master (output in, input out, valid);
    modport slave  (input in, output out, valid);
endinterface

// File: rtl/priority_cd.sv
// Registered most-significant-set-bit encoder: index of the highest '1' in bus.in
// plus a non-zero flag, one register stage after a log-depth binary-search core.
module priority_cd #(
    parameter int IN_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    priority_cd_if.slave   bus
);
    localparam int OUT_WIDTH = $clog2(IN_WIDTH);
    localparam int PAD_WIDTH = 1 << OUT_WIDTH;

    logic [PAD_WIDTH-1:0] padded;
    logic [PAD_WIDTH-1:0] window;
    logic [OUT_WIDTH-1:0] out_d, out_q;
    logic                 valid_d, valid_q;
    int                   half;

    // Each level halves the window: keep the upper half if it holds any set bit,
    // otherwise keep the lower half. Zero-extension keeps out below IN_WIDTH.
    always_comb begin
        padded = '0;
        padded[IN_WIDTH-1:0] = bus.in;
        window = padded;
        out_d = '0;
        half = 0;
        for (int k = 0; k < OUT_WIDTH; k++) begin
            half = PAD_WIDTH >> (k + 1);
            if (|(window >> half)) begin
                out_d[OUT_WIDTH-1-k] = 1'b1;
                window = window >> half;
            end else begin
                window = window & ({PAD_WIDTH{1'b1}} >> (PAD_WIDTH - half));
            end
        end
        valid_d = |bus.in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_priority_cd.sv
// Self-checking bench for priority_cd at IN_WIDTH 8 and 5, scoreboard-driven with
// a vector table, an 800-cycle counter sweep and asynchronous reset sequences.
module tb_priority_cd;
    logic clk;
    logic rst;
    int   testCount;
    int   failCount;

    typedef struct {
        logic [2:0] out8;
        logic       valid8;
        logic [2:0] out5;
        logic       valid5;
    } expT;

    typedef struct {
        logic [7:0] in8;
        logic [4:0] in5;
        logic [2:0] out8;
        logic       valid8;
        logic [2:0] out5;
        logic       valid5;
    } vecT;

    localparam int NV = 18;
    vecT vec [0:NV-1];
    expT sb[$];

    priority_cd_if #(.IN_WIDTH(8)) bus8();
    priority_cd_if #(.IN_WIDTH(5)) bus5();

    priority_cd #(.IN_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    priority_cd #(.IN_WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] msbIndex(input logic [7:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = i;
        end
        return 3'(r);
    endfunction

    task automatic checkOne(input string name, input int act, input int req);
        testCount++;
        if (act != req) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Results of the previous drive are visible at this negedge.
    task automatic checkOutput();
        expT e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOne("out8", int'(bus8.out), int'(e.out8));
            checkOne("valid8", int'(bus8.valid), int'(e.valid8));
            checkOne("out5", int'(bus5.out), int'(e.out5));
            checkOne("valid5", int'(bus5.valid), int'(e.valid5));
            testCount++;
            if (bus5.out > 3'd4) begin
                failCount++;
                $display("[TB] FAIL out5_range: got %0d, expected <= 4", bus5.out);
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] v8, input logic [4:0] v5,
                                 input logic [2:0] o8, input logic e8,
                                 input logic [2:0] o5, input logic e5);
        expT e;
        @(negedge clk);
        checkOutput();
        bus8.in = v8;
        bus5.in = v5;
        e.out8 = o8; e.valid8 = e8; e.out5 = o5; e.valid5 = e5;
        sb.push_back(e);
    endtask

    task automatic flush();
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        expT e;
        logic [7:0] v8;
        logic [4:0] v5;
        testCount = 0;
        failCount = 0;

        vec[0]  = '{8'h01, 5'b10000, 3'd0, 1'b1, 3'd4, 1'b1};
        vec[1]  = '{8'h02, 5'b01111, 3'd1, 1'b1, 3'd3, 1'b1};
        vec[2]  = '{8'h04, 5'b00000, 3'd2, 1'b1, 3'd0, 1'b0};
        vec[3]  = '{8'h08, 5'b00001, 3'd3, 1'b1, 3'd0, 1'b1};
        vec[4]  = '{8'h10, 5'b00010, 3'd4, 1'b1, 3'd1, 1'b1};
        vec[5]  = '{8'h20, 5'b00100, 3'd5, 1'b1, 3'd2, 1'b1};
        vec[6]  = '{8'h40, 5'b01000, 3'd6, 1'b1, 3'd3, 1'b1};
        vec[7]  = '{8'h80, 5'b11111, 3'd7, 1'b1, 3'd4, 1'b1};
        vec[8]  = '{8'h00, 5'b00000, 3'd0, 1'b0, 3'd0, 1'b0};
        vec[9]  = '{8'h80, 5'b10101, 3'd7, 1'b1, 3'd4, 1'b1};
        vec[10] = '{8'hFF, 5'b00111, 3'd7, 1'b1, 3'd2, 1'b1};
        vec[11] = '{8'hAA, 5'b00011, 3'd7, 1'b1, 3'd1, 1'b1};
        vec[12] = '{8'h17, 5'b01010, 3'd4, 1'b1, 3'd3, 1'b1};
        vec[13] = '{8'h80, 5'b10000, 3'd7, 1'b1, 3'd4, 1'b1};
        vec[14] = '{8'h01, 5'b00001, 3'd0, 1'b1, 3'd0, 1'b1};
        vec[15] = '{8'h80, 5'b10000, 3'd7, 1'b1, 3'd4, 1'b1};
        vec[16] = '{8'h01, 5'b00001, 3'd0, 1'b1, 3'd0, 1'b1};
        vec[17] = '{8'h80, 5'b10000, 3'd7, 1'b1, 3'd4, 1'b1};

        // Reset asserted between edges must clear outputs without a clock edge.
        rst = 1'b0;
        bus8.in = 8'hFF;
        bus5.in = 5'h1F;
        #2 rst = 1'b1;
        #1;
        checkOne("reset_out8", int'(bus8.out), 0);
        checkOne("reset_valid8", int'(bus8.valid), 0);
        checkOne("reset_out5", int'(bus5.out), 0);
        repeat (2) @(negedge clk);
        checkOne("reset_hold_valid8", int'(bus8.valid), 0);
        rst = 1'b0;
        e.out8 = 3'd7; e.valid8 = 1'b1; e.out5 = 3'd4; e.valid5 = 1'b1;
        sb.push_back(e);
        flush();

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vec[i].in8, vec[i].in5, vec[i].out8, vec[i].valid8,
                          vec[i].out5, vec[i].valid5);
        end

        for (int c = 0; c < 800; c++) begin
            v8 = 8'(c);
            v5 = 5'(c);
            applyStimulus(v8, v5, msbIndex(v8), |v8, msbIndex({3'b000, v5}), |v5);
        end
        flush();

        // Mid-cycle reset discards the registered result.
        applyStimulus(8'hFF, 5'h1F, 3'd7, 1'b1, 3'd4, 1'b1);
        flush();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOne("midreset_out8", int'(bus8.out), 0);
        checkOne("midreset_valid8", int'(bus8.valid), 0);
        checkOne("midreset_valid5", int'(bus5.valid), 0);
        sb.delete();
        @(negedge clk);
        checkOne("midreset_hold_out8", int'(bus8.out), 0);
        rst = 1'b0;
        e.out8 = 3'd7; e.valid8 = 1'b1; e.out5 = 3'd4; e.valid5 = 1'b1;
        sb.push_back(e);
        flush();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/priority_cd.md
Name: priority_cd

Overview:
- Registered most-significant-set-bit (priority) encoder.
- Reports the bit index of the highest '1' in an IN_WIDTH-bit input vector, plus a valid flag for the all-zero case.
- Used wherever a normalisation shift amount or highest-priority requester index is needed.
- One register stage sits between the combinational encoder and the outputs.

Parameters:
- IN_WIDTH, 8, width of input vector; legal range 2..256, need not be a power of two.
- OUT_WIDTH, $clog2(IN_WIDTH), localparam, width of the index output; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in  input  IN_WIDTH  vector to encode; bit IN_WIDTH-1 has highest priority.
- out  output  OUT_WIDTH  index of highest set bit of `in`, registered.
- valid  output  1  1 when the sampled `in` was non-zero, registered.

Behaviour:
- Reset:
  - rst high immediately forces out = 0 and valid = 0, independent of clk.
  - Outputs hold those values while rst is asserted.
  - The first capture happens on the first rising clk edge after rst deasserts.
- Latency:
  - Exactly 1 cycle; no handshake or stall.
  - `in` sampled on rising edge N appears on out/valid after edge N and holds until edge N+1.
  - A new input is accepted every cycle (throughput 1/cycle).
- Encoding:
  - out = max{i : in[i] == 1}, i.e. floor(log2(in)) for in != 0.
  - Lower set bits are ignored.
  - valid = |in.
- All-zero input:
  - out = 0 and valid = 0.
  - Consumers distinguish in == 1 (out = 0, valid = 1) from in == 0 (out = 0, valid = 0) only via valid.
- Structure:
  - Combinational core is a log-depth binary search, OUT_WIDTH levels.
  - Level k decides out[OUT_WIDTH-1-k] by testing whether any bit is set in the upper half of the currently selected window (window bits masked per level).
  - A linear priority chain is also acceptable if it meets timing; the result must be bit-identical.
- Non-power-of-two widths:
  - Input is conceptually zero-extended to 2**OUT_WIDTH bits.
  - out never exceeds IN_WIDTH-1.
- Width rules: out is unsigned. No X on outputs after reset, even if `in` contains X/Z bits.
- Reset mid-operation: an in-flight result is discarded; outputs return to 0/0 asynchronously.
- Purely single-clock; no other state.

Test Plan:
- Reset: assert rst with in = 8'hFF mid-cycle -> out = 0, valid = 0 immediately, without waiting for a clk edge. Release rst -> after next edge out = 7, valid = 1.
- Exhaustive counter sweep (IN_WIDTH = 8): drive in = 0,1,2,...,255, incrementing every cycle, repeated for 800 cycles including wrap-around 255 -> 0. One cycle after each value, required out is:
  - 0..1 -> 0 (valid 0 then 1)
  - 2..3 -> 1
  - 4..7 -> 2
  - 8..15 -> 3
  - 16..31 -> 4
  - 32..63 -> 5
  - 64..127 -> 6
  - 128..255 -> 7
- One-hot walk: in = 1<<i for i = 0..7 -> out = i, valid = 1. Then in = 0 -> out = 0, valid = 0.
- Lower-bit independence: in = 8'b1000_0000 vs 8'hFF vs 8'b1010_1010 -> out = 7 for all. in = 8'b0001_0111 -> out = 4.
- Non-power-of-two (IN_WIDTH = 5, OUT_WIDTH = 3): in = 5'b10000 -> out = 4; in = 5'b01111 -> out = 3; in = 0 -> valid = 0. out must never be 5..7.
- Back-to-back throughput: alternate in = 8'h80 / 8'h01 every cycle -> out alternates 7 / 0 with exactly one-cycle lag, valid held at 1.
